// File: rtl/apb_master.sv
// APB requester bridge.
// Takes single read/write commands on a valid/ready port and runs the
// APB SETUP -> ACCESS sequence. It waits for PREADY, then reports the
// result on a one-cycle response strobe. A bounded wait aborts transfers
// to a slave that never raises PREADY.
//
// Ports:
//   PCLK, PRESETn         clock; synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata  command payload
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read data (0 for writes and timeouts)
//   rsp_timeout           marks a response as a timeout abort
//   PADDR/PWRITE/PWDATA   APB request signals (registered)
//   PSELx/PENABLE         APB phase controls (registered)
//   PREADY/PRDATA         APB slave response
module apb_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  // Counter is wide enough to hold TIMEOUT; at least one bit when disabled.
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  assign cmd_ready = PRESETn && (state == IDLE);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= IDLE;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
          if (cmd_valid) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_wdata;
            // Outputs are registered, so raise PSELx as SETUP is entered.
            PSELx  <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          PSELx    <= 1'b1;
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end else if ((TIMEOUT != 0) && (wait_cnt == TLAST)) begin
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b1;
            state       <= IDLE;
          end else if (wait_cnt != '1) begin
            // Saturate rather than wrap when waiting forever.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          PSELx   <= 1'b0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4). Inputs change and outputs are
// checked at the falling edge, so each check sees the state after the
// preceding rising edge.
module tb_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic [15:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PSELx;
  logic        PENABLE;
  logic        PREADY;
  logic [31:0] PRDATA;

  int passed = 0;
  int total  = 0;

  apb_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .TIMEOUT   (4)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSELx      (PSELx),
    .PENABLE    (PENABLE),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  initial begin
    int en_cycles;

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PREADY    = 1'b0;
    PRDATA    = 32'h0BAD_0BAD;
    @(negedge PCLK);
    tick();
    tick();

    // Reset state
    check("rst_psel",    64'(PSELx),       64'd0);
    check("rst_penable", 64'(PENABLE),     64'd0);
    check("rst_paddr",   64'(PADDR),       64'd0);
    check("rst_pwrite",  64'(PWRITE),      64'd0);
    check("rst_pwdata",  64'(PWDATA),      64'd0);
    check("rst_rspv",    64'(rsp_valid),   64'd0);
    check("rst_rdata",   64'(rsp_rdata),   64'd0);
    check("rst_tmo",     64'(rsp_timeout), 64'd0);
    check("rst_ready",   64'(cmd_ready),   64'd0);
    PRESETn = 1'b1;
    tick();
    check("idle_ready",  64'(cmd_ready),   64'd1);

    // Write, zero wait states
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0010;
    cmd_wdata = 32'hDEAD_BEEF;
    PREADY    = 1'b1;
    tick();                                   // accepted at edge N
    cmd_valid = 1'b0;
    check("w_setup_psel",   64'(PSELx),   64'd1);
    check("w_setup_pen",    64'(PENABLE), 64'd0);
    check("w_paddr",        64'(PADDR),   64'h0010);
    check("w_pwdata",       64'(PWDATA),  64'hDEAD_BEEF);
    check("w_pwrite",       64'(PWRITE),  64'd1);
    check("w_setup_ready",  64'(cmd_ready), 64'd0);
    tick();
    check("w_acc_psel",     64'(PSELx),   64'd1);
    check("w_acc_pen",      64'(PENABLE), 64'd1);
    check("w_acc_rspv",     64'(rsp_valid), 64'd0);
    check("w_acc_paddr",    64'(PADDR),   64'h0010);
    tick();
    check("w_rspv",         64'(rsp_valid),   64'd1);
    check("w_rdata",        64'(rsp_rdata),   64'd0);
    check("w_tmo",          64'(rsp_timeout), 64'd0);
    check("w_done_psel",    64'(PSELx),       64'd0);
    check("w_done_pen",     64'(PENABLE),     64'd0);
    check("w_done_ready",   64'(cmd_ready),   64'd1);
    check("w_hold_paddr",   64'(PADDR),       64'h0010);
    tick();
    check("w_rspv_pulse",   64'(rsp_valid),   64'd0);

    // Read with 3 wait states
    PREADY    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h00A4;
    tick();
    cmd_valid = 1'b0;
    tick();                                   // first ACCESS cycle
    en_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (PENABLE) en_cycles++;
      check("r_wait_rspv", 64'(rsp_valid), 64'd0);
      tick();
    end
    PREADY = 1'b1;
    PRDATA = 32'h1234_5678;
    if (PENABLE) en_cycles++;
    tick();
    check("r_pen_cycles", 64'(en_cycles), 64'd4);
    check("r_rspv",       64'(rsp_valid), 64'd1);
    check("r_rdata",      64'(rsp_rdata), 64'h1234_5678);
    check("r_tmo",        64'(rsp_timeout), 64'd0);
    PRDATA = 32'hFFFF_0000;
    tick();
    check("r_rspv_pulse", 64'(rsp_valid), 64'd0);
    check("r_rdata_hold", 64'(rsp_rdata), 64'h1234_5678);

    // Timeout: PREADY held low
    PREADY    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0020;
    cmd_wdata = 32'h0000_0055;
    tick();
    cmd_valid = 1'b0;
    tick();
    en_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (PENABLE && PSELx) en_cycles++;
      check("t_wait_rspv", 64'(rsp_valid), 64'd0);
      tick();
    end
    check("t_acc_cycles", 64'(en_cycles),   64'd4);
    check("t_rspv",       64'(rsp_valid),   64'd1);
    check("t_tmo",        64'(rsp_timeout), 64'd1);
    check("t_rdata",      64'(rsp_rdata),   64'd0);
    check("t_psel",       64'(PSELx),       64'd0);
    check("t_pen",        64'(PENABLE),     64'd0);
    check("t_ready",      64'(cmd_ready),   64'd1);

    // Back-to-back with cmd_valid held high
    PREADY    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0004;
    cmd_wdata = 32'hA5A5_A5A5;
    tick();                                   // first accepted at N
    cmd_write = 1'b0;
    cmd_addr  = 16'h0008;
    check("b_n1_ready", 64'(cmd_ready), 64'd0);
    check("b_n1_paddr", 64'(PADDR),     64'h0004);
    tick();
    check("b_n2_paddr", 64'(PADDR),     64'h0004);
    check("b_n2_pen",   64'(PENABLE),   64'd1);
    PRDATA = 32'hCAFE_F00D;
    tick();
    check("b_n3_psel",  64'(PSELx),     64'd0);
    check("b_n3_rspv",  64'(rsp_valid), 64'd1);
    check("b_n3_tmo",   64'(rsp_timeout), 64'd0);
    check("b_n3_ready", 64'(cmd_ready), 64'd1);
    tick();                                   // second accepted at N+3
    cmd_valid = 1'b0;
    check("b_n4_psel",   64'(PSELx),    64'd1);
    check("b_n4_paddr",  64'(PADDR),    64'h0008);
    check("b_n4_pwrite", 64'(PWRITE),   64'd0);
    check("b_n4_rspv",   64'(rsp_valid), 64'd0);
    tick();
    tick();
    check("b_rspv2",     64'(rsp_valid), 64'd1);
    check("b_rdata2",    64'(rsp_rdata), 64'hCAFE_F00D);

    // Reset during ACCESS
    PREADY    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0030;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("x_acc_pen", 64'(PENABLE), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("x_ready_comb", 64'(cmd_ready), 64'd0);
    tick();
    check("x_psel",  64'(PSELx),     64'd0);
    check("x_pen",   64'(PENABLE),   64'd0);
    check("x_paddr", 64'(PADDR),     64'd0);
    check("x_rspv",  64'(rsp_valid), 64'd0);
    check("x_ready", 64'(cmd_ready), 64'd0);
    PRESETn = 1'b1;
    tick();
    check("x_rel_ready", 64'(cmd_ready), 64'd1);
    check("x_rel_rspv",  64'(rsp_valid), 64'd0);

    // Stability: PREADY/PRDATA activity in IDLE is ignored
    for (int i = 0; i < 4; i++) begin
      PREADY = i[0];
      PRDATA = 32'h1111_1111 * (i + 1);
      tick();
      check("s_idle_psel", 64'(PSELx),     64'd0);
      check("s_idle_rspv", 64'(rsp_valid), 64'd0);
    end
    PREADY    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0055;
    cmd_wdata = 32'h1122_3344;
    tick();                                   // SETUP with PREADY high
    cmd_addr  = 16'hFFFF;
    cmd_wdata = 32'h0000_0000;
    cmd_write = 1'b0;
    check("s_setup_pen",  64'(PENABLE),   64'd0);
    check("s_setup_rspv", 64'(rsp_valid), 64'd0);
    PREADY = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      cmd_addr  = cmd_addr ^ 16'h5A5A;
      cmd_wdata = cmd_wdata ^ 32'hF0F0_F0F0;
      PRDATA    = PRDATA ^ 32'h0F0F_0F0F;
      check("s_acc_paddr",  64'(PADDR),  64'h0055);
      check("s_acc_pwdata", 64'(PWDATA), 64'h1122_3344);
      check("s_acc_pwrite", 64'(PWRITE), 64'd1);
      tick();
    end
    cmd_valid = 1'b0;
    PREADY    = 1'b1;
    tick();
    check("s_rspv",  64'(rsp_valid), 64'd1);
    check("s_rdata", 64'(rsp_rdata), 64'd0);
    tick();
    check("s_idle_after", 64'(PSELx), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester (master) bridge: the initiating end of the APB slave interface.
- Accepts single read/write commands on a valid/ready command port and drives the PSELx/PENABLE/PADDR/PWRITE/PWDATA SETUP→ACCESS sequence.
- Waits on PREADY, then returns PRDATA (reads) or completion (writes) on a one-cycle response strobe.
- Bounded-wait timeout aborts transfers to a hung slave; drives the test/bench side of the existing APB interface in RTL form.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata.
- ADDR_WIDTH, 16, width of PADDR/cmd_addr.
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout (wait forever).

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master can accept a command this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  qualifies rsp_valid: transfer aborted by timeout.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  slave read data.

Behaviour:
- One clock, PCLK. Reset PRESETn is synchronous, active-low.
- Reset values: state IDLE; PSELx=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0; rsp_valid=0, rsp_rdata=0, rsp_timeout=0; wait counter=0.
- cmd_ready is forced 0 while PRESETn=0.
- All APB and rsp outputs are registered. cmd_ready is combinational: 1 iff state==IDLE and PRESETn=1.
- FSM states IDLE, SETUP, ACCESS.
- IDLE:
  - PSELx=0, PENABLE=0.
  - On cmd_valid&&cmd_ready, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA and go to SETUP.
- SETUP (exactly 1 cycle):
  - PSELx=1, PENABLE=0.
  - Go to ACCESS; clear the wait counter.
- ACCESS:
  - PSELx=1, PENABLE=1.
  - If PREADY=1 at the edge: go to IDLE; pulse rsp_valid next cycle; rsp_rdata=PRDATA if read, else 0; rsp_timeout=0.
  - Else, if TIMEOUT≠0 and the wait counter reaches TIMEOUT-1: go to IDLE; pulse rsp_valid with rsp_timeout=1 and rsp_rdata=0.
  - Else: increment the counter and stay in ACCESS.
- Latency: command accepted at edge N. PSELx high in cycle N+1 (SETUP) and PENABLE high in N+2. With zero wait states, rsp_valid is high in N+3, concurrent with IDLE. Minimum command spacing is 3 cycles.
- PADDR/PWRITE/PWDATA are held stable from SETUP through the end of ACCESS. They keep their last values in IDLE and change only on command acceptance.
- PRDATA is sampled only on the completing ACCESS edge. It is ignored in all other cycles, and for writes.
- rsp_valid is exactly 1 cycle per accepted command; there is no response backpressure. rsp_rdata/rsp_timeout hold their value until the next rsp_valid.
- cmd_valid while not in IDLE: ignored (cmd_ready=0); the command is not consumed.
- PREADY high during IDLE/SETUP: ignored.
- Reset mid-transfer: at the next edge with PRESETn=0, return to IDLE with PSELx/PENABLE=0 and no rsp_valid. The in-flight command is dropped.
- Timeout counter width: clog2(TIMEOUT+1), minimum 1 bit. The counter saturates and does not wrap.

Test Plan:
- Write, zero-wait: cmd write addr 0x0010, data 0xDEADBEEF; PREADY tied 1 -> PSELx rises N+1, PENABLE N+2, PADDR=0x0010, PWDATA=0xDEADBEEF, PWRITE=1 stable; rsp_valid=1 at N+3, rsp_rdata=0, rsp_timeout=0.
- Read with 3 wait states: cmd read addr 0x00A4; PREADY low for 3 ACCESS cycles then high with PRDATA=0x12345678 -> PENABLE high 4 cycles; rsp_valid once with rsp_rdata=0x12345678.
- Timeout: TIMEOUT=4, PREADY held 0 -> ACCESS lasts 4 cycles; PSELx/PENABLE drop; rsp_valid=1, rsp_timeout=1, rsp_rdata=0; next command accepted normally.
- Back-to-back: cmd_valid held high with write 0x0004 then read 0x0008, PREADY=1 -> second command accepted only in IDLE, 3 cycles after the first; PSELx low for exactly 1 cycle between transfers; two rsp_valid pulses.
- Reset mid-ACCESS: assert PRESETn=0 during ACCESS with PREADY=0 -> next edge PSELx=0, PENABLE=0, PADDR=0, cmd_ready=0; no rsp_valid; after release, cmd_ready=1.
- Stability: PRDATA toggling randomly and PREADY pulsing during IDLE/SETUP -> no state change and no rsp_valid; PADDR/PWDATA unchanged while cmd inputs toggle during a transfer.
